// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP checker among NrReq requesters: requester 0 has fixed priority, the rest rotate round-robin.
// Optional macro PMP_ARB_PIPE_EN lets a new request be accepted in the same cycle that the previous result is consumed.
module pmp_check_arbiter #(
    parameter int unsigned NrReq   = 3,
    parameter int unsigned PLEN    = 34,
    parameter int unsigned AccessW = 3,
    parameter int unsigned PrivW   = 2,
    localparam int unsigned IdW    = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NrReq-1:0]               req_valid_i,
    output logic [NrReq-1:0]               req_ready_o,
    input  logic [NrReq-1:0][PLEN-1:0]     req_addr_i,
    input  logic [NrReq-1:0][AccessW-1:0]  req_access_i,
    input  logic [NrReq-1:0][PrivW-1:0]    req_priv_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [IdW-1:0]                 resp_id_o,
    output logic                           resp_allow_o,
    output logic [PLEN-1:0]                pmp_addr_o,
    output logic [AccessW-1:0]             pmp_access_o,
    output logic [PrivW-1:0]               pmp_priv_o,
    input  logic                           pmp_allow_i,
    output logic [1:0]                     dbg_state_o,
    output logic [IdW-1:0]                 dbg_rr_ptr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Machine-mode privilege encoding.
    localparam logic [PrivW-1:0] PrivLvlM = '1;

    // Handshakes: a request is accepted when req_valid_i[i] && req_ready_o[i]; a result is consumed when resp_valid_o && resp_ready_i.
    state_e             state_q, state_d;
    logic [IdW-1:0]     id_q;
    logic [IdW-1:0]     rr_ptr_q;
    logic [NrReq-1:0]   eff_valid;
    logic               grant_valid;
    logic [IdW-1:0]     grant_idx;
    logic [IdW-1:0]     scan_idx;
    logic               arb_en;
    logic               accept;
    logic               drop;

    always_comb begin
        eff_valid   = req_valid_i;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        // A flush during the result cycle may only let the PTW through.
        if (state_q == RESP && flush_i) begin
            eff_valid[NrReq-1:1] = '0;
        end
        if (eff_valid[0]) begin
            grant_valid = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NrReq - 1; k++) begin
                scan_idx = IdW'((32'(rr_ptr_q) - 32'd1 + k) % (NrReq - 1) + 1);
                if (!grant_valid && eff_valid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

`ifdef PMP_ARB_PIPE_EN
    assign arb_en = (state_q == IDLE) || (state_q == RESP && resp_ready_i);
`else
    assign arb_en = (state_q == IDLE);
`endif

    assign accept = arb_en && grant_valid;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // The PTW is never flushed; a consumed result beats a flush in the same cycle.
    assign drop = flush_i && (id_q != '0) &&
                  ((state_q == BUSY) || (state_q == RESP && !resp_ready_i));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    state_d = drop ? IDLE : RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = accept ? BUSY : IDLE;
                end else if (drop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            id_q         <= '0;
            rr_ptr_q     <= IdW'(1);
            resp_valid_o <= 1'b0;
            resp_allow_o <= 1'b0;
            pmp_addr_o   <= '0;
            pmp_access_o <= '0;
            pmp_priv_o   <= PrivLvlM;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pmp_addr_o   <= req_addr_i[grant_idx];
                pmp_access_o <= req_access_i[grant_idx];
                pmp_priv_o   <= req_priv_i[grant_idx];
                id_q         <= grant_idx;
                if (grant_idx != '0) begin
                    rr_ptr_q <= (grant_idx == IdW'(NrReq - 1)) ? IdW'(1) : IdW'(grant_idx + 1'b1);
                end
            end
            if (state_q == BUSY && !drop) begin
                resp_valid_o <= 1'b1;
                resp_allow_o <= pmp_allow_i;
            end else if (state_q == RESP && (resp_ready_i || drop)) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

    assign resp_id_o    = id_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed-vector bench for pmp_check_arbiter; builds with or without PMP_ARB_PIPE_EN.
module tb_pmp_check_arbiter;

    localparam int NrReq = 3;
    localparam int PLEN  = 34;
    localparam int IdW   = 2;
`ifdef PMP_ARB_PIPE_EN
    localparam int Period = 2;
`else
    localparam int Period = 3;
`endif

    logic                        clk_i;
    logic                        rst_ni;
    logic                        flush_i;
    logic [NrReq-1:0]            req_valid_i;
    logic [NrReq-1:0]            req_ready_o;
    logic [NrReq-1:0][PLEN-1:0]  req_addr_i;
    logic [NrReq-1:0][2:0]       req_access_i;
    logic [NrReq-1:0][1:0]       req_priv_i;
    logic                        resp_valid_o;
    logic                        resp_ready_i;
    logic [IdW-1:0]              resp_id_o;
    logic                        resp_allow_o;
    logic [PLEN-1:0]             pmp_addr_o;
    logic [2:0]                  pmp_access_o;
    logic [1:0]                  pmp_priv_o;
    logic                        pmp_allow_i;
    logic [1:0]                  dbg_state_o;
    logic [IdW-1:0]              dbg_rr_ptr_o;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [IdW-1:0] exp_q[$];

    pmp_check_arbiter #(.NrReq(NrReq), .PLEN(PLEN), .AccessW(3), .PrivW(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_access_i(req_access_i), .req_priv_i(req_priv_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o), .resp_allow_o(resp_allow_o),
        .pmp_addr_o(pmp_addr_o), .pmp_access_o(pmp_access_o), .pmp_priv_o(pmp_priv_o),
        .pmp_allow_i(pmp_allow_i), .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        flush_i     = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // One full transaction from IDLE with the result consumed immediately.
    task automatic txn(input string tag, input logic [2:0] valid, input logic [2:0] exp_rdy,
                       input logic [1:0] exp_id);
        req_valid_i  = valid;
        resp_ready_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(req_ready_o), 64'(exp_rdy));
        step();
        req_valid_i = '0;
        #1;
        chk({tag, "_addr"}, 64'(pmp_addr_o), 64'h1000 * (64'(exp_id) + 1));
        step();
        #1;
        chk({tag, "_vld"}, 64'(resp_valid_o), 64'd1);
        chk({tag, "_id"}, 64'(resp_id_o), 64'(exp_id));
        step();
    endtask

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = '0;
        resp_ready_i = 1'b0;
        pmp_allow_i  = 1'b0;
        for (int r = 0; r < NrReq; r++) begin
            req_addr_i[r]   = PLEN'(34'h1000 * (r + 1));
            req_access_i[r] = 3'b001;
            req_priv_i[r]   = 2'b01;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rdy", 64'(req_ready_o), 64'd0);
        chk("rst_vld", 64'(resp_valid_o), 64'd0);
        chk("rst_id", 64'(resp_id_o), 64'd0);
        chk("rst_allow", 64'(resp_allow_o), 64'd0);
        chk("rst_addr", 64'(pmp_addr_o), 64'd0);
        chk("rst_acc", 64'(pmp_access_o), 64'd0);
        chk("rst_priv", 64'(pmp_priv_o), 64'd3);
        chk("rst_rr", 64'(dbg_rr_ptr_o), 64'd1);
        chk("rst_state", 64'(dbg_state_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // T1: single fetch, exec in user mode
        req_addr_i[1]   = 34'h0_8000_0000;
        req_access_i[1] = 3'b100;
        req_priv_i[1]   = 2'b00;
        pmp_allow_i     = 1'b1;
        resp_ready_i    = 1'b1;
        req_valid_i     = 3'b010;
        #1;
        chk("t1_rdy", 64'(req_ready_o), 64'b010);
        step();
        req_valid_i = '0;
        #1;
        chk("t1_addr", 64'(pmp_addr_o), 64'h8000_0000);
        chk("t1_acc", 64'(pmp_access_o), 64'd4);
        chk("t1_priv", 64'(pmp_priv_o), 64'd0);
        chk("t1_vld_c1", 64'(resp_valid_o), 64'd0);
        step();
        chk("t1_vld_c2", 64'(resp_valid_o), 64'd1);
        chk("t1_id", 64'(resp_id_o), 64'd1);
        chk("t1_allow", 64'(resp_allow_o), 64'd1);
        chk("t1_addr_c2", 64'(pmp_addr_o), 64'h8000_0000);
        step();
        chk("t1_vld_c3", 64'(resp_valid_o), 64'd0);
        chk("t1_idle", 64'(dbg_state_o), 64'd0);
        req_addr_i[1]   = 34'h2000;
        req_access_i[1] = 3'b001;

        // T2: priority and round-robin
        reset_dut();
        txn("t2a", 3'b111, 3'b001, 2'd0);
        txn("t2b", 3'b110, 3'b010, 2'd1);
        txn("t2c", 3'b110, 3'b100, 2'd2);
        txn("t2d", 3'b110, 3'b010, 2'd1);
        txn("t2e", 3'b111, 3'b001, 2'd0);
        txn("t2f", 3'b110, 3'b100, 2'd2);
        txn("t2g", 3'b010, 3'b010, 2'd1);
        chk("t2_rr", 64'(dbg_rr_ptr_o), 64'd2);

        // T3: backpressure with a deny result
        pmp_allow_i  = 1'b0;
        resp_ready_i = 1'b0;
        req_valid_i  = 3'b100;
        #1;
        chk("t3_rdy", 64'(req_ready_o), 64'b100);
        step();
        req_valid_i = 3'b011;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_vld", 64'(resp_valid_o), 64'd1);
            chk("t3_id", 64'(resp_id_o), 64'd2);
            chk("t3_allow", 64'(resp_allow_o), 64'd0);
            chk("t3_rdy_hold", 64'(req_ready_o), 64'd0);
            pmp_allow_i = 1'b1;
            step();
        end
        req_valid_i  = '0;
        resp_ready_i = 1'b1;
        #1;
        chk("t3_vld_last", 64'(resp_valid_o), 64'd1);
        step();
        chk("t3_vld_done", 64'(resp_valid_o), 64'd0);
        chk("t3_idle", 64'(dbg_state_o), 64'd0);

        // T4: flush of LSU in BUSY, PTW ignores flush, flush of fetch in RESP, flush in IDLE
        req_valid_i = 3'b100;
        #1;
        chk("t4a_rdy", 64'(req_ready_o), 64'b100);
        step();
        req_valid_i = '0;
        flush_i     = 1'b1;
        #1;
        chk("t4a_busy", 64'(dbg_state_o), 64'd1);
        step();
        chk("t4a_idle", 64'(dbg_state_o), 64'd0);
        chk("t4a_vld", 64'(resp_valid_o), 64'd0);
        flush_i = 1'b0;
        step();
        chk("t4a_vld2", 64'(resp_valid_o), 64'd0);

        req_valid_i = 3'b001;
        #1;
        chk("t4b_rdy", 64'(req_ready_o), 64'b001);
        step();
        req_valid_i  = '0;
        flush_i      = 1'b1;
        resp_ready_i = 1'b0;
        step();
        chk("t4b_vld", 64'(resp_valid_o), 64'd1);
        chk("t4b_id", 64'(resp_id_o), 64'd0);
        step();
        chk("t4b_vld_hold", 64'(resp_valid_o), 64'd1);
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;
        step();
        chk("t4b_vld_done", 64'(resp_valid_o), 64'd0);

        req_valid_i  = 3'b010;
        resp_ready_i = 1'b0;
        #1;
        chk("t4c_rdy", 64'(req_ready_o), 64'b010);
        step();
        req_valid_i = '0;
        step();
        chk("t4c_vld", 64'(resp_valid_o), 64'd1);
        flush_i = 1'b1;
        step();
        chk("t4c_vld_drop", 64'(resp_valid_o), 64'd0);
        chk("t4c_idle", 64'(dbg_state_o), 64'd0);

        req_valid_i = 3'b100;
        #1;
        chk("t4d_rdy", 64'(req_ready_o), 64'b100);
        step();
        flush_i      = 1'b0;
        req_valid_i  = '0;
        resp_ready_i = 1'b1;
        step();
        chk("t4d_vld", 64'(resp_valid_o), 64'd1);
        chk("t4d_id", 64'(resp_id_o), 64'd2);
        step();

        // T5: reset while holding a result
        req_valid_i  = 3'b010;
        resp_ready_i = 1'b0;
        step();
        req_valid_i = '0;
        step();
        chk("t5_vld_pre", 64'(resp_valid_o), 64'd1);
        chk("t5_rr_pre", 64'(dbg_rr_ptr_o), 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("t5_vld", 64'(resp_valid_o), 64'd0);
        chk("t5_rr", 64'(dbg_rr_ptr_o), 64'd1);
        chk("t5_priv", 64'(pmp_priv_o), 64'd3);
        chk("t5_state", 64'(dbg_state_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        txn("t5g", 3'b110, 3'b010, 2'd1);

        // T6: continuous fetch/LSU traffic throughput
        reset_dut();
        for (int i = 0; i < 6; i++) exp_q.push_back(IdW'((i % 2) + 1));
        resp_ready_i = 1'b1;
        req_valid_i  = 3'b110;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (c >= 2 && (c - 2) % Period == 0) begin
                chk("t6_vld", 64'(resp_valid_o), 64'd1);
                chk("t6_id", 64'(resp_id_o), 64'(exp_q.pop_front()));
            end else begin
                chk("t6_idle_vld", 64'(resp_valid_o), 64'd0);
            end
            step();
        end
        req_valid_i = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
